// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared defaults and helpers for the button debouncer
package btn_debounce_pkg;

  // Defaults shared by the RTL and the firmware headers
  localparam int         DEF_CHANNELS   = 8;
  localparam int         DEF_TICK_DIV   = 1600;
  localparam int         DEF_DEB_TICKS  = 8;
  localparam logic [7:0] DEF_ADDR_STATE = 8'h23;
  localparam logic [7:0] DEF_ADDR_EVT   = 8'h24;
  localparam logic [7:0] DEF_ADDR_IEN   = 8'h25;

  // Width of a counter that must hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_deb_ch.sv
// rtl/btn_deb_ch.sv - single-channel synchroniser, debounce counter and stable level
module btn_deb_ch
  import btn_debounce_pkg::*;
#(
  parameter int DEB_TICKS = DEF_DEB_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic tick,
  output logic stable,
  output logic press
);

  localparam int            CW       = cnt_width(DEB_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          accept;

  // A new level is accepted on the tick that completes the hold period
  assign accept = (sync2 != stable) && tick && (cnt == CNT_LAST);
  // Only a transition to the pressed (low) level is an event
  assign press  = accept && !sync2;

  // Two-flop synchroniser; idles at released so reset never fakes a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count ticks while the input disagrees; any agreement restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b1;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - debounced button inputs with press-event register and interrupt
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int         CHANNELS   = DEF_CHANNELS,
  parameter int         TICK_DIV   = DEF_TICK_DIV,
  parameter int         DEB_TICKS  = DEF_DEB_TICKS,
  parameter logic [7:0] ADDR_STATE = DEF_ADDR_STATE,
  parameter logic [7:0] ADDR_EVT   = DEF_ADDR_EVT,
  parameter logic [7:0] ADDR_IEN   = DEF_ADDR_IEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] stable_out,
  input  logic [7:0]          addr,
  input  logic                wr,
  input  logic                rd,
  input  logic [7:0]          bus_in,
  output logic [7:0]          bus_out,
  output logic                irq
);

  localparam int            PW       = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]       pre_cnt;
  logic                tick;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] evt;
  logic [CHANNELS-1:0] ien;
  logic [CHANNELS-1:0] evt_clr;
  logic                sel_state;
  logic                sel_evt;
  logic                sel_ien;

  assign tick = (pre_cnt == PRE_LAST);

  // Free-running prescaler shared by all channels; input activity never restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    btn_deb_ch #(
      .DEB_TICKS(DEB_TICKS)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_in[i]),
      .tick  (tick),
      .stable(stable_out[i]),
      .press (press[i])
    );
  end

  assign sel_state = (addr == ADDR_STATE);
  assign sel_evt   = (addr == ADDR_EVT);
  assign sel_ien   = (addr == ADDR_IEN);
  assign evt_clr   = (wr && sel_evt) ? bus_in[CHANNELS-1:0] : '0;

  // Event flags (set beats W1C clear), interrupt enables and registered irq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt <= '0;
      ien <= '0;
      irq <= 1'b0;
    end else begin
      evt <= (evt & ~evt_clr) | press;
      if (wr && sel_ien) begin
        ien <= bus_in[CHANNELS-1:0];
      end
      irq <= |(evt & ien);
    end
  end

  // Zero when unselected so the result can be OR-ed onto the shared read bus
  always_comb begin
    bus_out = '0;
    if (rd) begin
      if (sel_state) begin
        bus_out[CHANNELS-1:0] = stable_out;
      end else if (sel_evt) begin
        bus_out[CHANNELS-1:0] = evt;
      end else if (sel_ien) begin
        bus_out[CHANNELS-1:0] = ien;
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - scoreboard bench for btn_debounce against a tick-counting model
module tb_btn_debounce;

  localparam int TD  = 4;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] raw_in = 8'hFF;
  logic [7:0] stable_out;
  logic [7:0] addr = 8'h00;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] bus_in = 8'h00;
  logic [7:0] bus_out;
  logic       irq;

  btn_debounce #(
    .CHANNELS (8),
    .TICK_DIV (TD),
    .DEB_TICKS(DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .stable_out(stable_out),
    .addr      (addr),
    .wr        (wr),
    .rd        (rd),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pins seen two edges later, a level is accepted after
  // DEB consecutive ticks of disagreement, ticks every TD-th edge after reset.
  logic [7:0] m_pin [2];
  logic [7:0] m_st, m_evt, m_ien;
  logic       m_irq;
  int         m_tk [8];
  int         m_cyc;

  task automatic model_reset();
    m_pin[0] = 8'hFF;
    m_pin[1] = 8'hFF;
    m_st = 8'hFF; m_evt = 8'h00; m_ien = 8'h00; m_irq = 1'b0;
    m_cyc = 0;
    for (int i = 0; i < 8; i++) m_tk[i] = 0;
  endtask

  function automatic bit tick_now();
    return (m_cyc % TD) == (TD - 1);
  endfunction

  function automatic bit press_next(input int ch);
    return (m_pin[1][ch] == 1'b0) && (m_st[ch] == 1'b1) && tick_now() && (m_tk[ch] == DEB - 1);
  endfunction

  task automatic model_edge();
    logic [7:0] pr, seen, clr;
    bit t;
    pr = 8'h00;
    seen = m_pin[1];
    t = tick_now();
    for (int i = 0; i < 8; i++) begin
      if (seen[i] != m_st[i]) begin
        if (t) begin
          m_tk[i]++;
          if (m_tk[i] == DEB) begin
            m_tk[i] = 0;
            if (seen[i] == 1'b0) pr[i] = 1'b1;
            m_st[i] = seen[i];
          end
        end
      end else begin
        m_tk[i] = 0;
      end
    end
    m_pin[1] = m_pin[0];
    m_pin[0] = raw_in;
    clr = (wr && addr == 8'h24) ? bus_in : 8'h00;
    m_irq = |(m_evt & m_ien);
    m_evt = (m_evt & ~clr) | pr;
    if (wr && addr == 8'h25) m_ien = bus_in;
    m_cyc++;
  endtask

  function automatic logic [7:0] model_bus();
    if (!rd) return 8'h00;
    case (addr)
      8'h23:   return m_st;
      8'h24:   return m_evt;
      8'h25:   return m_ien;
      default: return 8'h00;
    endcase
  endfunction

  typedef struct {
    logic [7:0] st;
    logic       irq;
    logic [7:0] bus;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_stable", {24'h0, stable_out}, {24'h0, e.st});
      chk("sb_irq", {31'h0, irq}, {31'h0, e.irq});
      chk("sb_bus", {24'h0, bus_out}, {24'h0, e.bus});
    end
  end

  // One clock of stimulus: drive, publish expectation, advance model across the edge
  task automatic cyc(input logic [7:0] r, input logic rdv, input logic wrv,
                     input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    raw_in = r; rd = rdv; wr = wrv; addr = a; bus_in = d;
    if (rst) model_reset();
    e.st = m_st; e.irq = m_irq; e.bus = model_bus();
    exp_q.push_back(e);
    if (!rst) model_edge();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] raw_cur = 8'hFF;

  task automatic read_expect(input logic [7:0] a, input logic [7:0] v, input string name);
    rd = 1'b1; addr = a; wr = 1'b0;
    #1;
    chk(name, {24'h0, bus_out}, {24'h0, v});
    cyc(raw_cur, 1'b1, 1'b0, a, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  found;
    int  hold [8];
    model_reset();
    @(posedge clk);
    #1;
    cyc(raw_cur, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc(raw_cur, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;

    // 1: reset state and address decode
    chk("rst_stable", {24'h0, stable_out}, 32'hFF);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    read_expect(8'h23, 8'hFF, "rd_state");
    read_expect(8'h24, 8'h00, "rd_evt");
    read_expect(8'h25, 8'h00, "rd_ien");
    read_expect(8'h10, 8'h00, "rd_other");
    rd = 1'b0; addr = 8'h23;
    #1;
    chk("rd_idle", {24'h0, bus_out}, 32'h0);

    // 2: held press on channel 2, latency window
    raw_cur[2] = 1'b0;
    n = 0;
    do begin
      cyc(raw_cur, 1'b0, 1'b0, 8'h00, 8'h00);
      n++;
    end while (stable_out[2] && n < 30);
    chk("deb_latency_ok", {31'h0, (n >= 11 && n <= 14)}, 32'h1);
    read_expect(8'h24, 8'h04, "evt_ch2");
    chk("irq_masked", {31'h0, irq}, 32'h0);

    // 3: short bounces on channel 0 are rejected
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 6; j++) cyc(raw_cur & 8'hFE, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int j = 0; j < 6; j++) cyc(raw_cur, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    chk("bounce_stable0", {31'h0, stable_out[0]}, 32'h1);
    read_expect(8'h24, 8'h04, "bounce_evt");

    // 4: enable then clear interrupt
    cyc(raw_cur, 1'b0, 1'b1, 8'h25, 8'h04);
    chk("irq_not_yet", {31'h0, irq}, 32'h0);
    cyc(raw_cur, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("irq_rise", {31'h0, irq}, 32'h1);
    cyc(raw_cur, 1'b0, 1'b1, 8'h24, 8'h04);
    cyc(raw_cur, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("irq_fall", {31'h0, irq}, 32'h0);
    read_expect(8'h24, 8'h00, "evt_cleared");

    // 5: clear written on the exact acceptance edge of channel 0
    raw_cur[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      found = press_next(0);
      cyc(raw_cur, 1'b0, found, 8'h24, found ? 8'h01 : 8'h00);
    end
    chk("set_wins_found", {31'h0, found}, 32'h1);
    read_expect(8'h24, 8'h01, "set_wins");

    // 6: reset mid-debounce on channel 5
    raw_cur[5] = 1'b0;
    n = 0;
    while (m_tk[5] != 2 && n < 40) begin
      cyc(raw_cur, 1'b0, 1'b0, 8'h00, 8'h00);
      n++;
    end
    chk("ch5_cnt2_reached", {31'h0, (m_tk[5] == 2)}, 32'h1);
    rst = 1'b1;
    rd = 1'b1; addr = 8'h24;
    #1;
    chk("arst_stable", {24'h0, stable_out}, 32'hFF);
    chk("arst_irq", {31'h0, irq}, 32'h0);
    chk("arst_evt", {24'h0, bus_out}, 32'h0);
    for (int k = 0; k < 3; k++) cyc(raw_cur, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) cyc(raw_cur, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("post_rst_early", {24'h0, stable_out}, 32'hFF);
    for (int k = 0; k < 10; k++) cyc(raw_cur, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("post_rst_stable", {24'h0, stable_out}, 32'hDA);
    read_expect(8'h24, 8'h25, "post_rst_evt");

    // Random phase: independent per-channel bouncing plus random bus traffic
    for (int i = 0; i < 8; i++) hold[i] = 0;
    for (int k = 0; k < 500; k++) begin
      logic [7:0] a, d;
      logic rv, wv;
      int op;
      for (int i = 0; i < 8; i++) begin
        if (hold[i] == 0) begin
          if ($urandom_range(0, 1) == 1) raw_cur[i] = ~raw_cur[i];
          hold[i] = $urandom_range(1, 18);
        end
        hold[i]--;
      end
      op = $urandom_range(0, 9);
      rv = 1'b0; wv = 1'b0; a = 8'h00; d = 8'($urandom);
      case (op)
        0: begin wv = 1'b1; a = 8'h24; end
        1: begin wv = 1'b1; a = 8'h25; end
        2: begin wv = 1'b1; a = 8'h23; end
        3, 4, 5: begin
          rv = 1'b1;
          case ($urandom_range(0, 3))
            0: a = 8'h23;
            1: a = 8'h24;
            2: a = 8'h25;
            default: a = 8'h40;
          endcase
        end
        default: ;
      endcase
      cyc(raw_cur, rv, wv, a, d);
    end

    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
